// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the uart transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;
  localparam int UART_DATA_W = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd40000;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin winner search upward from ptr, wrapping at N-1
module uart_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int IW = $clog2(N);
  // scan offsets from far to near so the nearest set bit at or after ptr writes last
  always_comb begin
    idx = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter with packet lock (optional watchdog: UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          NUM_REQ        = DEF_NUM_REQ,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nx;
  logic lock, pick_found, sel_valid, fire, drop, done_ok, expire;
  logic [IW-1:0] rr_ptr, pick_idx, nxt_ptr;
  logic [UART_DATA_W-1:0] sel_data;
  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // watchdog restarts on each issued byte and counts while waiting for tx_done
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo_cnt <= '0;
    else if (fire) tmo_cnt <= '0;
    else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 16'd1;
  assign expire = state == WAIT_DONE && !tx_done && tmo_cnt == TIMEOUT_CYCLES;
`else
  assign expire = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state: a late tx_done still completes normally in the watchdog expiry cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = pick_found ? LOAD : IDLE;
      LOAD:      state_nx = drop ? IDLE : fire ? WAIT_DONE : LOAD;
      WAIT_DONE: state_nx = done_ok ? (lock ? LOAD : IDLE) : expire ? IDLE : WAIT_DONE;
      default:   state_nx = IDLE;
    endcase
  end
  // decode of the per-cycle events that drive the registered outputs
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_data = req_data[{grant_id, 3'b000} +: UART_DATA_W];
    fire = state == LOAD && sel_valid && !tx_busy;
    drop = state == LOAD && !sel_valid;
    done_ok = state == WAIT_DONE && tx_done;
    nxt_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    busy = state != IDLE;
    err_timeout = expire;
  end
  // grant, pointer, lock and the byte handed to the transmitter; pulses land with tx_data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_id <= '0;
      rr_ptr <= '0;
      lock <= 1'b0;
      tx_data <= '0;
      tx_start <= 1'b0;
      req_ready <= '0;
    end else begin
      tx_start <= fire;
      req_ready <= fire ? NUM_REQ'(1) << grant_id : '0;
      if (state == IDLE && pick_found) grant_id <= pick_idx;
      if (fire) begin
        tx_data <= sel_data;
        lock <= ~req_last[grant_id];
      end
      if (drop || expire || (done_ok && !lock)) begin
        rr_ptr <= nxt_ptr;
        lock <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the round-robin uart transmit arbiter and its picker
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, tx_busy = 1'b0, tx_done = 1'b0, busy, err_timeout;
  logic [1:0] grant_id;
  int tests = 0, fails = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16'd20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_ptr, pk_idx;
  logic pk_found;
  uart_rr_pick #(.N(4)) u_pick (.req(pk_req), .ptr(pk_ptr), .idx(pk_idx), .found(pk_found));

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic found;
  } pick_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i] = v;
    req_data[8*i +: 8] = d;
    req_last[i] = l;
  endtask

  task automatic wait_start(input string name, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (tx_start !== 1'b1 && k < 40);
    if (tx_start !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: tx_start never seen, got 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic send_done(input int gap);
    repeat (gap) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pick_vec_t pv[10];
    int order[5];
    int k, prev, errs;
    pv[0] = '{4'b0000, 2'd0, 2'd0, 1'b0};
    pv[1] = '{4'b0001, 2'd0, 2'd0, 1'b1};
    pv[2] = '{4'b0100, 2'd3, 2'd2, 1'b1};
    pv[3] = '{4'b1000, 2'd0, 2'd3, 1'b1};
    pv[4] = '{4'b1010, 2'd2, 2'd3, 1'b1};
    pv[5] = '{4'b1010, 2'd0, 2'd1, 1'b1};
    pv[6] = '{4'b0011, 2'd2, 2'd0, 1'b1};
    pv[7] = '{4'b1111, 2'd1, 2'd1, 1'b1};
    pv[8] = '{4'b0110, 2'd3, 2'd1, 1'b1};
    pv[9] = '{4'b1001, 2'd1, 2'd3, 1'b1};
    for (int i = 0; i < 10; i++) begin
      pk_req = pv[i].req;
      pk_ptr = pv[i].ptr;
      #1;
      chk($sformatf("pick idx %0d", i), pk_idx, pv[i].idx);
      chk($sformatf("pick found %0d", i), pk_found, pv[i].found);
    end

    do_reset();
    chk("reset busy", busy, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset err_timeout", err_timeout, 0);

    set_req(2, 1'b1, 8'hA5, 1'b1);
    wait_start("single", k);
    chk("single latency", k, 2);
    chk("single grant", grant_id, 2);
    chk("single ready", req_ready, 4'b0100);
    chk("single data", tx_data, 8'hA5);
    chk("single busy", busy, 1);
    set_req(2, 1'b0, 8'h00, 1'b0);
    tick();
    chk("single start one cycle", tx_start, 0);
    chk("single ready one cycle", req_ready, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("single done busy", busy, 0);
    req_valid = 4'hF;
    req_last = 4'hF;
    tick();
    chk("single next from 3", grant_id, 3);

    do_reset();
    order = '{0, 1, 2, 3, 0};
    prev = -1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_start("rr", k);
      chk($sformatf("rr grant %0d", i), grant_id, order[i]);
      chk($sformatf("rr ready %0d", i), req_ready, 4'b1 << order[i]);
      chk($sformatf("rr data %0d", i), tx_data, 8'h40 + order[i]);
      chk($sformatf("rr no repeat %0d", i), int'(grant_id) != prev, 1);
      prev = grant_id;
      if (i == 4) req_valid = '0;
      send_done(10);
    end
    chk("rr idle", busy, 0);

    do_reset();
    set_req(1, 1'b1, 8'h10, 1'b0);
    wait_start("lock0", k);
    chk("lock0 grant", grant_id, 1);
    chk("lock0 data", tx_data, 8'h10);
    set_req(1, 1'b1, 8'h11, 1'b0);
    set_req(0, 1'b1, 8'h77, 1'b1);
    send_done(3);
    chk("lock held busy", busy, 1);
    chk("lock held grant", grant_id, 1);
    wait_start("lock1", k);
    chk("lock1 grant", grant_id, 1);
    chk("lock1 data", tx_data, 8'h11);
    set_req(1, 1'b1, 8'h12, 1'b1);
    send_done(3);
    wait_start("lock2", k);
    chk("lock2 grant", grant_id, 1);
    chk("lock2 data", tx_data, 8'h12);
    set_req(1, 1'b0, 8'h00, 1'b0);
    send_done(3);
    wait_start("lock3", k);
    chk("lock then req0 grant", grant_id, 0);
    chk("lock then req0 data", tx_data, 8'h77);
    req_valid = '0;
    send_done(2);

    do_reset();
    tx_busy = 1'b1;
    set_req(3, 1'b1, 8'h3C, 1'b1);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_start !== 1'b0 || req_ready !== '0) errs++;
    end
    chk("txbusy no pulse while busy", errs, 0);
    chk("txbusy grant", grant_id, 3);
    tx_busy = 1'b0;
    tick();
    chk("txbusy start", tx_start, 1);
    chk("txbusy ready", req_ready, 4'b1000);
    chk("txbusy data", tx_data, 8'h3C);

    do_reset();
    tx_busy = 1'b1;
    set_req(2, 1'b1, 8'h99, 1'b1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("stray done ignored busy", busy, 1);
    chk("stray done no start", tx_start, 0);
    set_req(2, 1'b0, 8'h00, 1'b0);
    tick();
    chk("release busy", busy, 0);
    chk("release no ready", req_ready, 0);
    tx_busy = 1'b0;
    set_req(2, 1'b1, 8'h99, 1'b1);
    set_req(3, 1'b1, 8'h98, 1'b1);
    tick();
    chk("release ptr advanced", grant_id, 3);

    do_reset();
    set_req(2, 1'b1, 8'h22, 1'b1);
    wait_start("pre-reset a", k);
    set_req(2, 1'b0, 8'h00, 1'b0);
    send_done(2);
    set_req(1, 1'b1, 8'h55, 1'b1);
    wait_start("pre-reset b", k);
    chk("pre-reset grant", grant_id, 1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async busy", busy, 0);
    chk("async tx_data", tx_data, 0);
    chk("async grant", grant_id, 0);
    chk("async tx_start", tx_start, 0);
    chk("async ready", req_ready, 0);
    req_valid = '0;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 8'hC0, 1'b1);
    set_req(3, 1'b1, 8'hC3, 1'b1);
    wait_start("post-reset a", k);
    chk("post-reset ptr zero", grant_id, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    send_done(2);
    wait_start("post-reset b", k);
    chk("post-reset req3", grant_id, 3);
    chk("post-reset req3 data", tx_data, 8'hC3);

    do_reset();
    set_req(1, 1'b1, 8'h66, 1'b0);
    wait_start("tmo", k);
    set_req(2, 1'b1, 8'h88, 1'b1);
    errs = 0;
`ifdef UART_ARB_TIMEOUT_EN
    repeat (19) begin
      tick();
      if (err_timeout !== 1'b0) errs++;
    end
    chk("tmo not early", errs, 0);
    tick();
    chk("tmo pulse", err_timeout, 1);
    tick();
    chk("tmo one cycle", err_timeout, 0);
`else
    repeat (25) begin
      tick();
      if (err_timeout !== 1'b0) errs++;
    end
    chk("no tmo err", errs, 0);
    chk("no tmo still busy", busy, 1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    send_done(1);
`endif
    wait_start("tmo next", k);
    chk("tmo pending granted", grant_id, 2);
    chk("tmo pending data", tx_data, 8'h88);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
